// File: rtl/shift_normalize.sv
// shift_normalize: six-register pipelined 32-bit normalizer (CLZ/CTZ plus shift), the inverse of the barrel shifter.
// Optional output backpressure is enabled with `define NORM_BACKPRESSURE_EN.
module shift_normalize (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] I,
  input  logic        R,
  input  logic        in_valid,
  output logic        in_ready,
`ifdef NORM_BACKPRESSURE_EN
  input  logic        out_ready,
`endif
  output logic [31:0] O,
  output logic [4:0]  S,
  output logic        Z,
  output logic        out_valid
);

  // Index 0 is the capture register; indices 1..5 are the 16/8/4/2/1 stages.
  logic [5:0][31:0] w;
  logic [5:0][4:0]  cnt;
  logic [5:0]       r;
  logic [5:0]       v;
  logic [5:1][31:0] nxt_w;
  logic [5:1][4:0]  nxt_c;
  logic             advance;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] y;
    for (int b = 0; b < 32; b++) y[b] = x[31-b];
    return y;
  endfunction

`ifdef NORM_BACKPRESSURE_EN
  assign advance = !(out_valid && !out_ready);
`else
  assign advance = 1'b1;
`endif
  assign in_ready = advance;

  // Stage j tests the top (32 >> j) bits, shifts them out if zero, and records that power of two in the count.
  always_comb begin
    nxt_w = '0;
    nxt_c = '0;
    for (int j = 1; j <= 5; j++) begin
      if ((w[j-1] & ~(32'hFFFF_FFFF >> (32 >> j))) == 32'd0) begin
        nxt_w[j] = w[j-1] << (32 >> j);
        nxt_c[j] = cnt[j-1] | 5'(32 >> j);
      end else begin
        nxt_w[j] = w[j-1];
        nxt_c[j] = cnt[j-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w         <= '0;
      cnt       <= '0;
      r         <= '0;
      v         <= '0;
      O         <= '0;
      S         <= '0;
      Z         <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      w[0]   <= R ? rev32(I) : I;
      cnt[0] <= '0;
      r[0]   <= R;
      v[0]   <= in_valid;
      for (int j = 1; j <= 5; j++) begin
        w[j]   <= nxt_w[j];
        cnt[j] <= nxt_c[j];
        r[j]   <= r[j-1];
        v[j]   <= v[j-1];
      end
      // Right mode worked on the mirrored word, so mirror it back on the way out.
      O         <= r[5] ? rev32(w[5]) : w[5];
      S         <= cnt[5];
      Z         <= (w[5] == 32'd0);
      out_valid <= v[5];
    end
  end

endmodule
